// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry result buffer per functional unit, one buffer granted onto the CDB per cycle.
// Build option CDB_RR_EN: round-robin arbitration; when undefined, the lowest index wins.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int PREG_BITS = 6,
    parameter int ROB_BITS  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rob_flush,
    input  logic [NUM_FU-1:0]                  fu_valid,
    output logic [NUM_FU-1:0]                  fu_ready,
    input  logic [NUM_FU-1:0][PREG_BITS-1:0]   fu_pd,
    input  logic [NUM_FU-1:0][4:0]             fu_rd,
    input  logic [NUM_FU-1:0][31:0]            fu_data,
    input  logic [NUM_FU-1:0][ROB_BITS-1:0]    fu_rob_idx,
    output logic                               cdb_valid,
    output logic [PREG_BITS-1:0]               cdb_pd,
    output logic [4:0]                         cdb_rd,
    output logic [31:0]                        cdb_data,
    output logic [ROB_BITS-1:0]                cdb_rob_idx,
    output logic [NUM_FU-1:0]                  cdb_grant
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]                buf_valid_q, buf_valid_d;
    logic [NUM_FU-1:0][PREG_BITS-1:0] pd_q;
    logic [NUM_FU-1:0][4:0]           rd_q;
    logic [NUM_FU-1:0][31:0]          data_q;
    logic [NUM_FU-1:0][ROB_BITS-1:0]  rob_q;
    logic [NUM_FU-1:0]                accept;

`ifdef CDB_RR_EN
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] cand, gidx;
`endif

    // Arbitration over registered buffers only, so no fu_* input reaches cdb_*.
    always_comb begin
        cdb_grant = '0;
`ifdef CDB_RR_EN
        cand = '0;
        gidx = rr_ptr_q;
        if (!rst && !rob_flush) begin
            for (int k = 0; k < NUM_FU; k++) begin
                cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_FU);
                if (cdb_grant == '0 && buf_valid_q[cand]) begin
                    cdb_grant[cand] = 1'b1;
                    gidx            = cand;
                end
            end
        end
`else
        if (!rst && !rob_flush) begin
            for (int i = NUM_FU - 1; i >= 0; i--) begin
                if (buf_valid_q[i]) begin
                    cdb_grant    = '0;
                    cdb_grant[i] = 1'b1;
                end
            end
        end
`endif
    end

    assign cdb_valid = |cdb_grant;

    // One-hot AND-OR mux: payload is all-zero when nothing is granted.
    always_comb begin
        cdb_pd      = '0;
        cdb_rd      = '0;
        cdb_data    = '0;
        cdb_rob_idx = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (cdb_grant[i]) begin
                cdb_pd      = cdb_pd | pd_q[i];
                cdb_rd      = cdb_rd | rd_q[i];
                cdb_data    = cdb_data | data_q[i];
                cdb_rob_idx = cdb_rob_idx | rob_q[i];
            end
        end
    end

    // A buffer being granted this cycle may be refilled on the same edge.
    assign fu_ready = {NUM_FU{!rst && !rob_flush}} & (~buf_valid_q | cdb_grant);
    assign accept   = fu_valid & fu_ready;

    always_comb begin
        buf_valid_d = (buf_valid_q & ~cdb_grant) | accept;
        if (rob_flush) begin
            buf_valid_d = '0;
        end
`ifdef CDB_RR_EN
        rr_ptr_d = rr_ptr_q;
        if (cdb_valid) begin
            rr_ptr_d = (gidx == PTR_W'(NUM_FU - 1)) ? '0 : gidx + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= '0;
`ifdef CDB_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            buf_valid_q <= buf_valid_d;
`ifdef CDB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                pd_q[i]   <= fu_pd[i];
                rd_q[i]   <= fu_rd[i];
                data_q[i] <= fu_data[i];
                rob_q[i]  <= fu_rob_idx[i];
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) among the out-of-order core's functional units. Each functional unit hands its completed result (physical destination, architectural destination, data, ROB index) to a one-entry holding buffer. Each cycle the arbiter grants exactly one occupied buffer onto the CDB. The CDB feeds the reservation stations' wakeup inputs (`pd_cdb`, `ready_commit_cdb`), the physical register file and the ROB. Buffers are cleared on ROB flush.

## Interface
Parameters:
- `NUM_FU`, 4, number of requesting functional units (≥2).
- `PREG_BITS`, 6, physical register index width (`$clog2(NUM_PHYS_REG)`).
- `ROB_BITS`, 4, ROB index width (`$clog2(ROB_DEPTH)`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rob_flush`  in  1  pipeline flush; discards all buffered results.
- `fu_valid`  in  `NUM_FU`  result valid from FU i.
- `fu_ready`  out  `NUM_FU`  FU i result accepted this cycle when `fu_valid[i]` is also high.
- `fu_pd`  in  `[NUM_FU-1:0][PREG_BITS-1:0]`  physical destination.
- `fu_rd`  in  `[NUM_FU-1:0][4:0]`  architectural destination.
- `fu_data`  in  `[NUM_FU-1:0][31:0]`  result value.
- `fu_rob_idx`  in  `[NUM_FU-1:0][ROB_BITS-1:0]`  ROB entry.
- `cdb_valid`  out  1  CDB broadcast valid (drives `ready_commit_cdb`).
- `cdb_pd`  out  `PREG_BITS`  broadcast physical destination.
- `cdb_rd`  out  5  broadcast architectural destination.
- `cdb_data`  out  32  broadcast value.
- `cdb_rob_idx`  out  `ROB_BITS`  broadcast ROB index.
- `cdb_grant`  out  `NUM_FU`  one-hot id of the buffer being broadcast; zero when idle.

## Operation
State:
- Per FU: `buf_valid[i]` and a payload register.
- `rr_ptr` (`$clog2(NUM_FU)` bits) when round-robin is compiled in.

Acceptance:
- `fu_ready[i] = !rob_flush && (!buf_valid[i] || cdb_grant[i])`.
- A handshake (`fu_valid[i] && fu_ready[i]`) loads the payload into buffer i and sets `buf_valid[i]` on the next edge.
- Grant and refill of the same buffer in the same cycle is legal. This gives back-to-back throughput of one result per cycle per FU when uncontested.

Arbitration (combinational from registered buffers):
- Candidates are buffers with `buf_valid[i]=1`.
- With round-robin: the first candidate scanning upward from `rr_ptr`, wrapping modulo `NUM_FU`.
- Exactly one bit of `cdb_grant` is set when any candidate exists; otherwise zero.
- `cdb_*` payload is driven from the granted buffer. It is all-zero when `cdb_valid=0`.
- A granted buffer clears `buf_valid` on the next edge unless it is refilled in the same cycle.
- After a grant to index g, `rr_ptr <= (g+1) mod NUM_FU`. With no grant, `rr_ptr` holds.

Flush:
- `rob_flush=1` forces `cdb_valid=0`, `cdb_grant=0` and `fu_ready=0` that cycle.
- All `buf_valid` clear on the next edge.
- `rr_ptr` holds across a flush.
- `fu_valid` asserted during flush is dropped. The FU must also be flushing.

Reset:
- All `buf_valid` are 0 and `rr_ptr` is 0.
- Consequently `cdb_valid`, `cdb_grant` and all `cdb_*` outputs are 0.
- `fu_ready` is all-ones after reset release, and 0 while `rst` is high.
- Reset dominates flush.

## Timing
- Latency: a result accepted at edge N is broadcast in cycle N+1 (`cdb_valid` high after edge N) when uncontested.
- Contention: with k occupied buffers under round-robin, each buffer waits at most `NUM_FU-1` cycles before grant.
- A waiting buffer holds `fu_ready[i]=0` until granted; its payload never changes while it waits.
- Throughput: one CDB broadcast per cycle maximum.
- No combinational path from any `fu_*` input to any `cdb_*` output.
- `fu_ready` depends only on registered state, `cdb_grant` and `rob_flush`.

## Configuration
`CDB_RR_EN`:
- Defined: round-robin arbitration with `rr_ptr` as described above.
- Undefined: fixed priority, lowest index wins. `rr_ptr` is not implemented. Starvation of high indices is permitted, and FU 0 is placed on the highest-urgency unit (ALU).
- All other behaviour is identical in both builds.

## Test plan
- **Reset release:** after `rst` drops, `cdb_valid=0`, `cdb_grant=0`, `fu_ready=4'b1111`.
- **Single uncontested result:** FU 2 result (`pd=6'd9`, `rd=5'd3`, `data=32'hDEADBEEF`, `rob=4'd5`) accepted at edge N. At N+1: `cdb_valid=1`, `cdb_grant=4'b0100` and the exact payload. At N+2: `cdb_valid=0`.
- **All four FUs fire in the same cycle from `rr_ptr=0` (`CDB_RR_EN`):** grants are 0001, 0010, 0100, 1000 on consecutive cycles. `fu_ready[3]` stays low for 3 cycles.
- **Same four-FU stimulus without `CDB_RR_EN`:** grants are in order 0,1,2,3. With FU 0 re-requesting every cycle, FU 1 is never granted.
- **Back-to-back on FU 1:** `fu_valid[1]` held for 4 cycles with distinct pd 1..4. `fu_ready[1]` stays 1 throughout. The CDB broadcasts pd 1,2,3,4 on consecutive cycles.
- **Flush mid-contention:** three buffers occupied and `rob_flush` pulsed. That cycle `cdb_valid=0` and `fu_ready=0`. Next cycle all buffers are empty and `rr_ptr` is unchanged. A new FU 3 result is then broadcast 1 cycle after acceptance.
